param_register_file: RTL and testbench

Parametrised multi-read-port register file for the single-cycle and pipelined datapaths. It generalises the fixed 32x64, two-read-port file with:
- configurable data width, depth, read-port count and hard-wired zero register;
- rising-edge writes with same-cycle write-to-read forwarding;
- a per-register pending scoreboard for multi-cycle producers;
- a clear sequencer that zeroes the whole array after reset or on request.

---
 rtl/param_register_file_if.sv | 28 ++
 rtl/param_register_file.sv | 137 +++++++++++++
 tb/tb_param_register_file.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/param_register_file_if.sv
// Bus-side signal bundle for param_register_file: read ports, write port,
// scoreboard controls and the array-ready status.
interface param_register_file_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2
);
  logic [NUM_READ*ADDR_WIDTH-1:0] RA;
  logic [NUM_READ*DATA_WIDTH-1:0] Bus;
  logic [NUM_READ-1:0]            Pend;
  logic [ADDR_WIDTH-1:0]          RW;
  logic [DATA_WIDTH-1:0]          BusW;
  logic                           RegWr;
  logic                           SetPend;
  logic [ADDR_WIDTH-1:0]          PendRd;
  logic                           ClearReq;
  logic                           Ready;

  modport master (
    output RA, RW, BusW, RegWr, SetPend, PendRd, ClearReq,
    input  Bus, Pend, Ready
  );

  modport slave (
    input  RA, RW, BusW, RegWr, SetPend, PendRd, ClearReq,
    output Bus, Pend, Ready
  );
endinterface

// File: rtl/param_register_file.sv
// Parametrised multi-read-port register file with write forwarding, a
// per-register pending scoreboard and a full-array clear sequencer.
//
// state    | meaning
// ST_CLEAR | zeroing register[cnt_q] each cycle, writes ignored, reads 0
// ST_READY | array valid, accepts writes, scoreboard updates, ClearReq
module param_register_file #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2,
  parameter bit ZERO_EN    = 1'b1,
  parameter int ZERO_IDX   = 31
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  param_register_file_if.slave  rf
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ZERO_IDX[ADDR_WIDTH-1:0];
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  if (NUM_READ < 1 || NUM_READ > 4) begin : g_bad_num_read
    $error("param_register_file: NUM_READ must be within 1..4");
  end
  if (ZERO_IDX < 0 || ZERO_IDX >= DEPTH) begin : g_bad_zero_idx
    $error("param_register_file: ZERO_IDX must be below DEPTH");
  end

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DEPTH-1:0]        pend_q, pend_d;
  logic                    ready_q, ready_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic                    fwd_ok;
  logic                    wr_is_zero;
  logic                    set_is_zero;

  // Forwarding qualifies on Ready only, so it stays a pure function of ports
  // plus one flop and does not depend on ClearReq.
  assign fwd_ok      = rf.RegWr && ready_q;
  assign wr_is_zero  = ZERO_EN && (rf.RW == ZERO_ADDR);
  assign set_is_zero = ZERO_EN && (rf.PendRd == ZERO_ADDR);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    wr_en   = 1'b0;
    wr_addr = rf.RW;
    wr_data = rf.BusW;
    case (state_q)
      ST_CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = cnt_q;
        wr_data = '0;
        pend_d  = '0;
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_READY: begin
        if (rf.ClearReq) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
          pend_d  = '0;
        end else begin
          if (rf.RegWr) begin
            pend_d[rf.RW] = 1'b0;
            wr_en         = !wr_is_zero;
          end
          // Applied after the clear so a new producer wins over a retiring one.
          if (rf.SetPend && !set_is_zero) begin
            pend_d[rf.PendRd] = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
        pend_d  = '0;
      end
    endcase
    ready_d = (state_d == ST_READY);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      pend_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ready_q <= ready_d;
    end
  end

  // The array has no reset; the clear sequencer is what makes it valid.
  always_ff @(posedge Clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic                  is_zero;
    logic                  fwd_hit;

    assign ra      = rf.RA[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign is_zero = ZERO_EN && (ra == ZERO_ADDR);
    assign fwd_hit = fwd_ok && (rf.RW == ra);

    assign rf.Bus[gi*DATA_WIDTH +: DATA_WIDTH] =
      (!ready_q || is_zero) ? '0 :
      fwd_hit               ? rf.BusW :
                              mem_q[ra];

    assign rf.Pend[gi] = ready_q && !is_zero && !fwd_hit && pend_q[ra];
  end

  assign rf.Ready = ready_q;
endmodule

// File: tb/tb_param_register_file.sv
// Randomized and directed bench for param_register_file: three configurations
// run in lockstep against a behavioural array/scoreboard model.
module tb_param_register_file;
  localparam int NK = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  param_register_file_if #(.DATA_WIDTH(64), .ADDR_WIDTH(5), .NUM_READ(2)) ifa ();
  param_register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_READ(3)) ifb ();
  param_register_file_if #(.DATA_WIDTH(64), .ADDR_WIDTH(5), .NUM_READ(2)) ifc ();

  param_register_file #(.DATA_WIDTH(64), .ADDR_WIDTH(5), .NUM_READ(2),
                        .ZERO_EN(1'b1), .ZERO_IDX(31))
    dut_a (.Clk(clk), .Reset_n(rst_n), .rf(ifa));
  param_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_READ(3),
                        .ZERO_EN(1'b1), .ZERO_IDX(15))
    dut_b (.Clk(clk), .Reset_n(rst_n), .rf(ifb));
  param_register_file #(.DATA_WIDTH(64), .ADDR_WIDTH(5), .NUM_READ(2),
                        .ZERO_EN(1'b0), .ZERO_IDX(31))
    dut_c (.Clk(clk), .Reset_n(rst_n), .rf(ifc));

  int cfg_w  [NK] = '{64, 32, 64};
  int cfg_aw [NK] = '{5, 4, 5};
  int cfg_nr [NK] = '{2, 3, 2};
  bit cfg_ze [NK] = '{1'b1, 1'b1, 1'b0};
  int cfg_zi [NK] = '{31, 15, 31};

  // Model: register contents, pending bits, and clear cycles still to go
  // (0 means the array is ready).
  logic [63:0] m_mem  [NK][32];
  bit          m_pend [NK][32];
  int          m_left [NK];

  logic [4:0]  ra [3];
  logic [4:0]  rw, pr;
  logic [63:0] busw;
  logic        regwr, setpend, clrreq;

  int checks = 0;
  int errors = 0;
  int lat_a, lat_b;

  function automatic int depth(int k);
    return 1 << cfg_aw[k];
  endfunction

  function automatic logic [63:0] dmask(int k);
    if (cfg_w[k] == 64) return '1;
    return (64'd1 << cfg_w[k]) - 64'd1;
  endfunction

  function automatic int am(int k, logic [4:0] a);
    return int'(a) & (depth(k) - 1);
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NK; k++) begin
      m_left[k] = depth(k);
      for (int a = 0; a < 32; a++) begin
        m_mem[k][a]  = '0;
        m_pend[k][a] = 1'b0;
      end
    end
  endtask

  function automatic bit is_zero_reg(int k, int a);
    return cfg_ze[k] && (a == cfg_zi[k]);
  endfunction

  function automatic logic [63:0] exp_bus(int k, int a);
    if (m_left[k] != 0) return '0;
    if (is_zero_reg(k, a)) return '0;
    if (regwr && am(k, rw) == a) return busw & dmask(k);
    return m_mem[k][a];
  endfunction

  function automatic bit exp_pend(int k, int a);
    if (m_left[k] != 0) return 1'b0;
    if (is_zero_reg(k, a)) return 1'b0;
    if (regwr && am(k, rw) == a) return 1'b0;
    return m_pend[k][a];
  endfunction

  function automatic logic [63:0] dut_bus(int k, int p);
    case (k)
      0:       return ifa.Bus[p*64 +: 64];
      1:       return {32'b0, ifb.Bus[p*32 +: 32]};
      default: return ifc.Bus[p*64 +: 64];
    endcase
  endfunction

  function automatic logic dut_pend(int k, int p);
    case (k)
      0:       return ifa.Pend[p];
      1:       return ifb.Pend[p];
      default: return ifc.Pend[p];
    endcase
  endfunction

  function automatic logic dut_ready(int k);
    case (k)
      0:       return ifa.Ready;
      1:       return ifb.Ready;
      default: return ifc.Ready;
    endcase
  endfunction

  task automatic model_edge(int k);
    int w, p;
    w = am(k, rw);
    p = am(k, pr);
    if (m_left[k] != 0) begin
      m_mem[k][depth(k) - m_left[k]] = '0;
      m_left[k]--;
    end else if (clrreq) begin
      m_left[k] = depth(k);
      for (int a = 0; a < 32; a++) m_pend[k][a] = 1'b0;
    end else begin
      if (regwr) begin
        if (!is_zero_reg(k, w)) m_mem[k][w] = busw & dmask(k);
        m_pend[k][w] = 1'b0;
      end
      if (setpend && !is_zero_reg(k, p)) m_pend[k][p] = 1'b1;
    end
  endtask

  task automatic drive_check();
    ifa.RA = {ra[1], ra[0]};
    ifa.RW = rw; ifa.BusW = busw; ifa.RegWr = regwr;
    ifa.SetPend = setpend; ifa.PendRd = pr; ifa.ClearReq = clrreq;
    ifb.RA = {ra[2][3:0], ra[1][3:0], ra[0][3:0]};
    ifb.RW = rw[3:0]; ifb.BusW = busw[31:0]; ifb.RegWr = regwr;
    ifb.SetPend = setpend; ifb.PendRd = pr[3:0]; ifb.ClearReq = clrreq;
    ifc.RA = {ra[1], ra[0]};
    ifc.RW = rw; ifc.BusW = busw; ifc.RegWr = regwr;
    ifc.SetPend = setpend; ifc.PendRd = pr; ifc.ClearReq = clrreq;
    if (!rst_n) model_reset();
    #1;
    for (int k = 0; k < NK; k++) begin
      chk($sformatf("k%0d ready", k), 64'(dut_ready(k)), 64'(m_left[k] == 0));
      for (int p = 0; p < cfg_nr[k]; p++) begin
        chk($sformatf("k%0d bus%0d ra=%0d", k, p, am(k, ra[p])),
            dut_bus(k, p), exp_bus(k, am(k, ra[p])));
        chk($sformatf("k%0d pend%0d ra=%0d", k, p, am(k, ra[p])),
            64'(dut_pend(k, p)), 64'(exp_pend(k, am(k, ra[p]))));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else for (int k = 0; k < NK; k++) model_edge(k);
    @(negedge clk);
  endtask

  task automatic step();
    drive_check();
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    for (int p = 0; p < 3; p++) ra[p] = '0;
    rw = '0; pr = '0; busw = '0;
    regwr = 1'b0; setpend = 1'b0; clrreq = 1'b0;
    model_reset();
    @(negedge clk);
    step();
    step();

    // Bring up, fill the array with junk, then reset on top of it.
    rst_n = 1'b1;
    for (int i = 0; i < 34; i++) step();
    regwr = 1'b1;
    for (int i = 0; i < 32; i++) begin
      rw = 5'(i); busw = {$urandom, $urandom}; ra[0] = 5'(i); ra[1] = 5'(31 - i);
      setpend = 1'($urandom_range(0, 1)); pr = 5'($urandom_range(0, 31));
      step();
    end
    regwr = 1'b0; setpend = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    // Reset again part-way through the clear; the sequence must restart.
    for (int i = 0; i < 10; i++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;

    lat_a = -1; lat_b = -1;
    for (int i = 0; i < 40; i++) begin
      if (ifa.Ready === 1'b1 && lat_a < 0) lat_a = i;
      if (ifb.Ready === 1'b1 && lat_b < 0) lat_b = i;
      regwr = (lat_a < 0);
      rw = 5'($urandom_range(0, 31)); busw = {$urandom, $urandom};
      ra[0] = 5'($urandom_range(0, 31)); ra[1] = rw; ra[2] = rw;
      step();
    end
    chk("ready_latency_a", 64'(lat_a), 64'(32));
    chk("ready_latency_b", 64'(lat_b), 64'(16));

    regwr = 1'b0;
    for (int i = 0; i < 32; i += 2) begin
      ra[0] = 5'(i); ra[1] = 5'(i + 1); ra[2] = 5'((i + 2) % 32);
      step();
    end

    // Write R5 with forwarding, then plain read.
    rw = 5'd5; busw = 64'hDEAD_BEEF_0123_4567; regwr = 1'b1; ra[0] = 5'd5;
    drive_check();
    chk("fwd_r5", ifa.Bus[63:0], 64'hDEAD_BEEF_0123_4567);
    tick();
    regwr = 1'b0; busw = 64'h0;
    drive_check();
    chk("read_r5", ifa.Bus[63:0], 64'hDEAD_BEEF_0123_4567);
    tick();

    // Zero register, with and without ZERO_EN.
    rw = 5'd31; busw = '1; regwr = 1'b1; setpend = 1'b1; pr = 5'd31;
    ra[0] = 5'd31; ra[1] = 5'd31;
    drive_check();
    chk("zero_a_fwd", ifa.Bus[63:0], 64'h0);
    chk("nozero_c_fwd", ifc.Bus[63:0], 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    regwr = 1'b0; setpend = 1'b0; busw = '0;
    drive_check();
    chk("zero_a_bus", ifa.Bus[63:0], 64'h0);
    chk("zero_a_pend", 64'(ifa.Pend[0]), 64'h0);
    chk("nozero_c_bus", ifc.Bus[63:0], 64'hFFFF_FFFF_FFFF_FFFF);
    chk("nozero_c_pend", 64'(ifc.Pend[0]), 64'h1);
    tick();

    // Scoreboard on R7.
    ra[0] = 5'd7; ra[1] = 5'd7; pr = 5'd7; setpend = 1'b1;
    drive_check();
    chk("pend_r7_same_cycle", 64'(ifa.Pend[0]), 64'h0);
    tick();
    setpend = 1'b0;
    drive_check();
    chk("pend_r7_set", 64'(ifa.Pend[0]), 64'h1);
    tick();
    rw = 5'd7; busw = 64'h7777; regwr = 1'b1;
    drive_check();
    chk("pend_r7_write_cycle", 64'(ifa.Pend[0]), 64'h0);
    tick();
    regwr = 1'b0;
    drive_check();
    chk("pend_r7_cleared", 64'(ifa.Pend[0]), 64'h0);
    tick();
    regwr = 1'b1; setpend = 1'b1; busw = 64'h8888;
    step();
    regwr = 1'b0; setpend = 1'b0;
    drive_check();
    chk("pend_r7_set_wins", 64'(ifa.Pend[0]), 64'h1);
    tick();

    // ClearReq beats a same-cycle write.
    rw = 5'd3; busw = 64'h55; regwr = 1'b1; ra[0] = 5'd3;
    step();
    pr = 5'd9; setpend = 1'b1; regwr = 1'b0;
    step();
    clrreq = 1'b1; regwr = 1'b1; busw = 64'hAA; setpend = 1'b1; pr = 5'd3;
    step();
    clrreq = 1'b0; regwr = 1'b0; setpend = 1'b0;
    drive_check();
    chk("clear_ready_drop", 64'(ifa.Ready), 64'h0);
    tick();
    for (int i = 0; i < 31; i++) step();
    drive_check();
    chk("clear_ready_back", 64'(ifa.Ready), 64'h1);
    chk("clear_r3_zero", ifa.Bus[63:0], 64'h0);
    tick();
    for (int i = 0; i < 32; i += 2) begin
      ra[0] = 5'(i); ra[1] = 5'(i + 1); ra[2] = 5'(i + 2);
      step();
    end

    // Three distinct reads on the narrow configuration.
    regwr = 1'b1;
    rw = 5'd1; busw = 64'h1111_2222_A1A1_A1A1; step();
    rw = 5'd2; busw = 64'h3333_4444_B2B2_B2B2; step();
    rw = 5'd3; busw = 64'h5555_6666_C3C3_C3C3; step();
    regwr = 1'b0;
    ra[0] = 5'd1; ra[1] = 5'd2; ra[2] = 5'd3;
    drive_check();
    chk("sweep_b_port0", {32'b0, ifb.Bus[31:0]},  64'hA1A1_A1A1);
    chk("sweep_b_port1", {32'b0, ifb.Bus[63:32]}, 64'hB2B2_B2B2);
    chk("sweep_b_port2", {32'b0, ifb.Bus[95:64]}, 64'hC3C3_C3C3);
    tick();

    // Random traffic, with occasional clears and resets.
    for (int i = 0; i < 1500; i++) begin
      rst_n   = ($urandom_range(0, 299) != 0);
      rw      = 5'($urandom_range(0, 31));
      busw    = {$urandom, $urandom};
      regwr   = 1'($urandom_range(0, 1));
      setpend = ($urandom_range(0, 2) == 0);
      clrreq  = ($urandom_range(0, 39) == 0) || (clrreq && $urandom_range(0, 1) == 1);
      for (int p = 0; p < 3; p++)
        ra[p] = ($urandom_range(0, 2) == 0) ? rw : 5'($urandom_range(0, 31));
      pr = ($urandom_range(0, 1) == 0) ? ra[0] : 5'($urandom_range(0, 31));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
